// File: rtl/tx_frame_arbiter_pkg.sv
// Shared definitions for the UART TX frame arbiter.
//   state_t  : scheduler FSM states
//   REQ_ALU  : requester id of the 16-bit ALU result source
//   REQ_RF   : requester id of the 8-bit register-file read source
package tx_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_RF  = 1'b1;

endpackage

// File: rtl/tx_frame_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : level requests, bit index = requester id
//   en         : a grant may be taken this cycle
//   gnt_valid  : a grant is taken this cycle (en and any request)
//   gnt_id     : id of the granted requester
// On every grant the pointer moves to the requester that was not granted,
// whether or not both were requesting.
module rr_arb2
  import tx_frame_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q;

  always_comb begin
    gnt_valid = en && (req != 2'b00);
    if (req == 2'b11) gnt_id = ptr_q;
    else              gnt_id = req[1];
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, regardless of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr_q <= REQ_ALU;
    else if (gnt_valid) ptr_q <= ~gnt_id;
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares one UART transmitter between the ALU result (two bytes, LSB first)
// and register-file read data (one byte).
//   clk, rst_n           : clock, asynchronous active-low reset
//   alu_req/alu_data     : ALU request level and 2*DATA_W result
//   alu_ack              : one-cycle pulse, alu_data has been captured
//   rf_req/rf_data       : register-file request level and DATA_W data
//   rf_ack               : one-cycle pulse, rf_data has been captured
//   tx_busy              : UART TX busy (already in the clk domain)
//   tx_valid/tx_data     : Data_Valid pulse and byte to UART TX
//   sched_busy           : a frame is in progress (state != IDLE)
//   retry_pulse          : one-cycle pulse on each timeout re-issue
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int TMR_W        = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_req,
  input  logic [2*DATA_W-1:0] alu_data,
  output logic                alu_ack,
  input  logic                rf_req,
  input  logic [DATA_W-1:0]   rf_data,
  output logic                rf_ack,
  input  logic                tx_busy,
  output logic                tx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic                sched_busy,
  output logic                retry_pulse
);

  state_t              state_q, state_d;
  logic [2*DATA_W-1:0] hold_q;
  logic                bytes_left_q;
  logic [TMR_W-1:0]    timer_q;
  logic [TMR_W-1:0]    timer_inc;
  logic                gnt_en, gnt_valid, gnt_id;
  logic                grant, timeout, next_byte;

  // Grants are only taken in IDLE with the transmitter free.
  assign gnt_en    = (state_q == IDLE) && !tx_busy;
  assign timer_inc = timer_q + 1'b1;

  // The byte on the wire is always the low byte of the hold register, so it
  // stays put from one ISSUE to the next without a separate data flop.
  assign tx_data = hold_q[DATA_W-1:0];

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({rf_req, alu_req}),
    .en       (gnt_en),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    timeout   = 1'b0;
    next_byte = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_HI;
      WAIT_HI: begin
        // A busy rise wins over a coincident timeout.
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (timer_inc == TMR_W'(BUSY_TIMEOUT - 1)) begin
          // The re-issue lands exactly BUSY_TIMEOUT cycles after the
          // previous tx_valid.
          timeout = 1'b1;
          state_d = ISSUE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (bytes_left_q) begin
            next_byte = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and are glitch-free at the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the hold register is reset too, because tx_data is taken
      // straight from it and must read 0 during and right after reset.
      state_q      <= IDLE;
      hold_q       <= '0;
      bytes_left_q <= 1'b0;
      timer_q      <= '0;
      tx_valid     <= 1'b0;
      sched_busy   <= 1'b0;
      retry_pulse  <= 1'b0;
      alu_ack      <= 1'b0;
      rf_ack       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_valid    <= (state_d == ISSUE);
      sched_busy  <= (state_d != IDLE);
      retry_pulse <= timeout;
      alu_ack     <= grant && (gnt_id == REQ_ALU);
      rf_ack      <= grant && (gnt_id == REQ_RF);

      if (grant) begin
        hold_q       <= (gnt_id == REQ_ALU) ? alu_data : {{DATA_W{1'b0}}, rf_data};
        bytes_left_q <= (gnt_id == REQ_ALU);
      end else if (next_byte) begin
        hold_q       <= hold_q >> DATA_W;
        bytes_left_q <= 1'b0;
      end

      if (state_q == ISSUE)                   timer_q <= '0;
      else if (state_q == WAIT_HI && !tx_busy) timer_q <= timer_inc;
    end
  end

endmodule
